rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Inverse of the core's immediate extender: packs a format code, register/function fields and a full 32-bit immediate into a 32-bit RV32I instruction word.
- Immediate bits are scattered per format: I, S, B, U or J.
- Used by the self-test/boot-loader path to build instruction words on the fly (patching branch/jump offsets, generating LUI/ADDI pairs) before they are written to instruction memory.
- Two-stage valid/ready pipeline: range-checks the immediate and flags values that cannot be encoded.

Parameters:
- CNT_W, 16, width of the saturating encode-error counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts request this cycle.
- in_fmt  in  3  000=I, 001=S, 010=B, 011=U, 100=J (same codes as the control unit's Imm_src); 101–111 illegal.
- in_opcode  in  7  opcode field, placed at inst[6:0].
- in_rd  in  5  destination register (I/U/J).
- in_rs1  in  5  source register 1 (I/S/B).
- in_rs2  in  5  source register 2 (S/B).
- in_funct3  in  3  funct3 field (I/S/B).
- in_imm  in  32  sign-extended immediate, byte offset for B/J, full upper value for U.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_inst  out  32  encoded instruction.
- out_err  out  1  immediate not representable, or illegal format.
- err_count  out  CNT_W  saturating count of accepted requests that produced out_err=1.

Behaviour:
- Reset (async assert, sync release):
  - Both stage valids = 0, so out_valid = 0.
  - out_inst = 0, out_err = 0, err_count = 0.
  - in_ready = 1 from the first cycle after release.
- Handshake:
  - Transfer on a clock edge with valid && ready.
  - Once out_valid is high, out_inst and out_err stay stable until the output handshake completes.
  - in_valid may drop without a transfer.
- Pipeline:
  - S1 registers the inputs and the range-check result.
  - S2 registers the packed word.
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s1_advance.
  - Latency: 2 cycles from accept to out_valid, with no stall.
  - Throughput: 1 per cycle with out_ready held high.
  - No bubble is inserted when both stages drain and fill in the same cycle.
- Packing (bit ranges refer to in_imm):
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Unused fields are ignored.
- Range check (err = 1 when the condition fails):
  - I/S: imm[31:11] all equal, i.e. fits signed 12 bits.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Error handling:
  - On err, out_inst still carries the truncated packing above.
  - Illegal fmt: out_inst=0, out_err=1.
  - err_count increments when an erroring request enters S1.
  - err_count saturates at all-ones and never wraps.
- Reset mid-operation: in-flight requests are discarded and no output handshake occurs for them.

Test Plan:
- I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> 0x00500093, err=0, out_valid exactly 2 cycles after accept.
- S, opcode 0x23, rs1=3, rs2=2, f3=2, imm=8 -> 0x0021A423; then B, opcode 0x63, rs1=rs2=0, f3=0, imm=0xFFFFFFFC -> 0xFE000EE3, sent back-to-back with out_ready=1 -> consecutive out_valid cycles.
- U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; J, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF.
- Errors:
  - I with imm=2048 -> out_err=1, err_count=1.
  - B with imm=3 -> out_err=1, err_count=2.
  - fmt=111 -> out_inst=0, out_err=1, err_count=3.
  - With CNT_W=2, a fourth error -> err_count holds at 3.
- Backpressure:
  - Hold out_ready=0 and offer 3 requests -> exactly 2 accepted, in_ready=0, out_inst stable.
  - Release out_ready -> outputs emerge in order with no loss or duplication.
- Assert rst with both stages full -> out_valid=0 immediately (async), err_count=0; next request encodes correctly with 2-cycle latency.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs format, register/function fields and a 32-bit immediate into an RV32I word.
// Two-stage valid/ready pipeline: S1 captures fields plus range check, S2 holds the packed word.
module rv_instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);
    logic             s1_valid_q, s1_err_q, s2_valid_q, s2_err_q, s1_err_d, s2_load;
    logic [2:0]       s1_fmt_q, s1_funct3_q;
    logic [6:0]       s1_opcode_q;
    logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0]      s1_imm_q, s2_inst_q, s2_inst_d;
    logic [CNT_W-1:0] err_count_q;

    // Upper immediate bits must be a pure sign extension; branch/jump offsets must be even.
    assign s1_err_d = (in_fmt == 3'd0 || in_fmt == 3'd1) ? !(&in_imm[31:11] || ~|in_imm[31:11]) :
                      (in_fmt == 3'd2) ? !(&in_imm[31:12] || ~|in_imm[31:12]) || in_imm[0] :
                      (in_fmt == 3'd3) ? |in_imm[11:0] :
                      (in_fmt == 3'd4) ? !(&in_imm[31:20] || ~|in_imm[31:20]) || in_imm[0] : 1'b1;

    assign s2_inst_d = (s1_fmt_q == 3'd0) ? {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q} :
                       (s1_fmt_q == 3'd1) ? {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                             s1_imm_q[4:0], s1_opcode_q} :
                       (s1_fmt_q == 3'd2) ? {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q} :
                       (s1_fmt_q == 3'd3) ? {s1_imm_q[31:12], s1_rd_q, s1_opcode_q} :
                       (s1_fmt_q == 3'd4) ? {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                             s1_rd_q, s1_opcode_q} : 32'd0;

    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_count = err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_fmt_q    <= '0;
            s1_funct3_q <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_inst_q   <= '0;
            err_count_q <= '0;
        end else begin
            if (in_ready)
                s1_valid_q <= in_valid;
            if (in_valid && in_ready) begin
                s1_err_q    <= s1_err_d;
                s1_fmt_q    <= in_fmt;
                s1_funct3_q <= in_funct3;
                s1_opcode_q <= in_opcode;
                s1_rd_q     <= in_rd;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_imm_q    <= in_imm;
                if (s1_err_d && !(&err_count_q))
                    err_count_q <= err_count_q + 1'b1;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_inst_q <= s2_inst_d;
                    s2_err_q  <= s1_err_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: scoreboard bench for rv_instr_encoder with directed and random requests.
// A second instance with a 2-bit error counter exercises counter saturation.
module tb_rv_instr_encoder;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0]  in_fmt = '0, in_funct3 = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2;
    logic [31:0] out_inst, out_inst2;
    logic [15:0] err_count;
    logic [1:0]  err_count2;

    int          n_cmp = 0, n_fail = 0, exp_errs = 0;
    logic [32:0] sb[$];
    bit          rand_ready = 0;

    rv_instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_count(err_count)
    );

    rv_instr_encoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm), .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
        .out_err(out_err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: field placement by arithmetic, range by signed bounds.
    function automatic logic [32:0] model(input int unsigned fmt, op, rd, rs1, rs2, f3, input logic [31:0] imm);
        int unsigned u = imm;
        longint      s = longint'($signed(imm));
        int unsigned inst = 0;
        bit          err = 1;
        case (fmt)
            0: begin inst = (u % 4096) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op; err = s < -2048 || s > 2047; end
            1: begin
                inst = ((u >> 5) % 128) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (u % 32) << 7 | op;
                err = s < -2048 || s > 2047;
            end
            2: begin
                inst = ((u >> 12) % 2) << 31 | ((u >> 5) % 64) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
                     | ((u >> 1) % 16) << 8 | ((u >> 11) % 2) << 7 | op;
                err = s < -4096 || s > 4095 || (u % 2) != 0;
            end
            3: begin inst = (u / 4096) * 4096 | rd << 7 | op; err = (u % 4096) != 0; end
            4: begin
                inst = ((u >> 20) % 2) << 31 | ((u >> 1) % 1024) << 21 | ((u >> 11) % 2) << 20
                     | ((u >> 12) % 256) << 12 | rd << 7 | op;
                err = s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 1 || (u % 2) != 0;
            end
            default: begin inst = 0; err = 1; end
        endcase
        return {err, inst[31:0]};
    endfunction

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [31:0] imm,
                        input bit use_exp = 0, input logic [31:0] e_inst = 0, input bit e_err = 0);
        logic [32:0] e;
        bit          done = 0;
        e = use_exp ? {e_err, e_inst} : model(fmt, op, rd, rs1, rs2, f3, imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                if (e[32]) exp_errs++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_cnt16"}, err_count, exp_errs > 65535 ? 65535 : exp_errs);
        chk({nm, "_cnt2"}, err_count2, exp_errs > 3 ? 3 : exp_errs);
    endtask

    // Monitor: pops on each output handshake and checks hold-stability under backpressure.
    initial begin
        bit          stall = 0;
        logic [32:0] prev = '0, e;
        forever begin
            @(negedge clk);
            if (rst) stall = 0;
            else begin
                if (stall) chk("hold_stable", {out_valid, out_err, out_inst}, {1'b1, prev});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_output", {out_err, out_inst}, 33'h1_DEAD_BEEF);
                    else begin
                        e = sb.pop_front();
                        chk("out_word", {out_err, out_inst}, e);
                    end
                end
                stall = out_valid && !out_ready;
                prev = {out_err, out_inst};
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(1));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        repeat (2) begin
            @(negedge clk);
            chk("rst_state", {out_valid, out_err, out_inst}, 0);
            chk_cnt("rst");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;
        send(0, 7'h13, 1, 0, 0, 0, 32'd5, 1, 32'h00500093, 0);
        @(negedge clk);
        chk("latency_c1", out_valid, 0);
        @(negedge clk);
        chk("latency_c2", out_valid, 1);
        drain();
        send(1, 7'h23, 0, 3, 2, 2, 32'd8, 1, 32'h0021A423, 0);
        send(2, 7'h63, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 32'hFE000EE3, 0);
        @(negedge clk);
        chk("b2b_first", out_valid, 1);
        @(negedge clk);
        chk("b2b_second", out_valid, 1);
        drain();
        send(3, 7'h37, 5, 0, 0, 0, 32'h12345000, 1, 32'h123452B7, 0);
        send(4, 7'h6F, 1, 0, 0, 0, 32'h800, 1, 32'h001000EF, 0);
        drain();
        chk_cnt("no_err");
        send(0, 7'h13, 1, 0, 0, 0, 32'd2048);
        drain();
        chk("err_i_cnt", err_count, 1);
        send(2, 7'h63, 0, 1, 2, 0, 32'd3);
        drain();
        chk("err_b_cnt", err_count, 2);
        send(7, 7'h13, 3, 4, 5, 1, 32'd0, 1, 32'd0, 1);
        drain();
        chk("err_fmt_cnt", err_count, 3);
        send(0, 7'h13, 1, 0, 0, 0, 32'd2048);
        drain();
        chk("err4_cnt16", err_count, 4);
        chk("err4_cnt2_sat", err_count2, 3);
        out_ready = 1'b0;
        send(0, 7'h13, 2, 3, 0, 0, 32'd100);
        send(1, 7'h23, 0, 4, 5, 2, 32'hFFFFFFF0);
        in_fmt = 3; in_opcode = 7'h17; in_rd = 7; in_imm = 32'hABCDE000; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        send(3, 7'h17, 7, 0, 0, 0, 32'hABCDE000);
        drain();
        out_ready = 1'b0;
        send(4, 7'h6F, 3, 0, 0, 0, 32'h0001_0000);
        send(0, 7'h13, 3, 3, 0, 0, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", err_count, 0);
        sb.delete();
        exp_errs = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(0, 7'h13, 1, 0, 0, 0, 32'd5, 1, 32'h00500093, 0);
        @(negedge clk);
        chk("post_rst_c1", out_valid, 0);
        @(negedge clk);
        chk("post_rst_c2", out_valid, 1);
        drain();
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(3))
                0: r = $urandom;
                1: r = $urandom_range(4095) - 32'd2048;
                2: r = $urandom & 32'hFFFFF000;
                default: r = $urandom_range(32'h200000) - 32'h100000;
            endcase
            send(3'($urandom_range(7) == 7 ? $urandom_range(5, 7) : $urandom_range(4)),
                 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), r);
            repeat ($urandom_range(1)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        chk_cnt("random_end");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
